// File: rtl/piano_pkg.sv
// Shared piano constants: board clock, key count and default debounce time.
package piano_pkg;

    localparam int unsigned PIANO_CLK_HZ      = 100_000_000;
    localparam int unsigned PIANO_N_KEYS      = 8;
    localparam int unsigned PIANO_DEBOUNCE_MS = 20;

    // Cycles of the board clock spanning a given number of milliseconds.
    function automatic int unsigned ms_to_cycles(input int unsigned clk_hz, input int unsigned ms);
        return (clk_hz / 1000) * ms;
    endfunction

    localparam int unsigned PIANO_DEBOUNCE_CYCLES = ms_to_cycles(PIANO_CLK_HZ, PIANO_DEBOUNCE_MS);

endpackage

// File: rtl/key_debounce_if.sv
// Raw switch inputs and debounced key/mode outputs of the debouncer.
interface key_debounce_if
    import piano_pkg::*;
#(
    parameter int unsigned N_KEYS = PIANO_N_KEYS
);
    logic [N_KEYS-1:0] key_raw;
    logic              mode_raw;
    logic [N_KEYS-1:0] key_level;
    logic [N_KEYS-1:0] key_press;
    logic              mode_level;
    logic              mode_pulse;
    logic              any_key;

    // Board side: drives the raw switches, consumes the clean levels/pulses.
    modport master (
        output key_raw, mode_raw,
        input  key_level, key_press, mode_level, mode_pulse, any_key
    );

    // Debouncer side.
    modport slave (
        input  key_raw, mode_raw,
        output key_level, key_press, mode_level, mode_pulse, any_key
    );
endinterface

// File: rtl/key_debounce_bit.sv
// One debounce channel: 2-flop synchronizer, stability counter, stable level
// and a one-cycle press pulse on each accepted 0->1 transition.
module debounce_bit
    import piano_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = PIANO_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic press
);
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             stable_q, stable_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next-state: count while the synchronized input disagrees with the
    // accepted level; accept it (and pulse on a rise) when the count completes.
    always_comb begin
        sync1_d  = din;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        press_d  = 1'b0;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_d = sync2_q;
            cnt_d    = '0;
            press_d  = sync2_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            press_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            press_q  <= press_d;
            cnt_q    <= cnt_d;
        end
    end

    assign level = stable_q;
    assign press = press_q;

endmodule

// File: rtl/key_debounce.sv
// Debouncer for the piano key switches and the mode button: one independent
// debounce_bit channel per input, plus a combinational any-key indicator.
module key_debounce
    import piano_pkg::*;
#(
    parameter int unsigned CLK_HZ          = PIANO_CLK_HZ,
    parameter int unsigned DEBOUNCE_CYCLES = PIANO_DEBOUNCE_CYCLES,
    parameter int unsigned N_KEYS          = PIANO_N_KEYS
) (
    input  logic               clk,
    input  logic               rst,
    key_debounce_if.slave      bus
);
    // Reject parameter sets outside the supported range at elaboration.
    if (CLK_HZ == 0 || DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 32'h00FF_FFFF) begin : g_bad_params
        $error("key_debounce: CLK_HZ must be nonzero and DEBOUNCE_CYCLES in 2..2^24-1");
    end

    // One channel per piano key.
    for (genvar i = 0; i < N_KEYS; i++) begin : g_key
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_key (
            .clk   (clk),
            .rst_n (rst),
            .din   (bus.key_raw[i]),
            .level (bus.key_level[i]),
            .press (bus.key_press[i])
        );
    end

    // Mode-select button channel.
    debounce_bit #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_mode (
        .clk   (clk),
        .rst_n (rst),
        .din   (bus.mode_raw),
        .level (bus.mode_level),
        .press (bus.mode_pulse)
    );

    assign bus.any_key = |bus.key_level;

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with DEBOUNCE_CYCLES=16 (18-cycle latency).
module tb_key_debounce;
    localparam int unsigned NK  = 8;
    localparam int unsigned LAT = 18;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    key_debounce_if #(.N_KEYS(NK)) dut_if ();

    key_debounce #(
        .CLK_HZ          (100_000_000),
        .DEBOUNCE_CYCLES (16),
        .N_KEYS          (NK)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (dut_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed view: {key_level, key_press, mode_level, mode_pulse, any_key}.
    function automatic logic [18:0] pack(input logic [7:0] lvl, input logic [7:0] prs,
                                         input logic ml, input logic mp, input logic ak);
        return {lvl, prs, ml, mp, ak};
    endfunction

    function automatic logic [18:0] expv(input logic [7:0] lvl, input logic [7:0] prs,
                                         input logic ml, input logic mp);
        return {lvl, prs, ml, mp, (lvl != 8'h00)};
    endfunction

    task automatic check(input string tag, input logic [18:0] got, input logic [18:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%05h expected=%05h (lvl,prs,ml,mp,any)", tag, got, exp);
        end
    endtask

    function automatic logic [18:0] obs();
        return pack(dut_if.key_level, dut_if.key_press, dut_if.mode_level,
                    dut_if.mode_pulse, dut_if.any_key);
    endfunction

    // Drive keys/mode at a falling edge, then for n cycles compare against a
    // level that switches from old to new after LAT rising edges.
    task automatic step_run(input string tag, input logic [7:0] k_old, input logic [7:0] k_new,
                            input logic m_old, input logic m_new, input int n);
        logic [7:0] lvl, prs;
        logic       ml, mp;
        dut_if.key_raw  = k_new;
        dut_if.mode_raw = m_new;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            lvl = (i >= LAT) ? k_new : k_old;
            ml  = (i >= LAT) ? m_new : m_old;
            prs = (i == LAT) ? (k_new & ~k_old) : 8'h00;
            mp  = (i == LAT) ? (m_new & ~m_old) : 1'b0;
            check($sformatf("%s_c%0d", tag, i), obs(), expv(lvl, prs, ml, mp));
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst             = 1'b0;
        dut_if.key_raw  = 8'hFF;
        dut_if.mode_raw = 1'b1;

        // Reset with all inputs high: everything held at 0.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("rst_hold_c%0d", i), obs(), '0);
        end
        // Release: inputs held high across release are accepted once, with one pulse.
        rst = 1'b1;
        step_run("rst_rel", 8'h00, 8'hFF, 1'b0, 1'b1, 22);

        // Release everything.
        step_run("all_off", 8'hFF, 8'h00, 1'b1, 1'b0, 22);

        // Glitch of 10 cycles on key 3 is rejected.
        dut_if.key_raw = 8'h08;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            check($sformatf("glitch_hi_c%0d", i), obs(), '0);
        end
        dut_if.key_raw = 8'h00;
        for (int i = 1; i <= 25; i++) begin
            @(negedge clk);
            check($sformatf("glitch_lo_c%0d", i), obs(), '0);
        end

        // Clean press and release of key 0.
        step_run("k0_press", 8'h00, 8'h01, 1'b0, 1'b0, 25);
        step_run("k0_rel",   8'h01, 8'h00, 1'b0, 1'b0, 25);

        // Mode bounce: toggle every 3 cycles through cycle 30, ending high.
        for (int c = 0; c <= 60; c++) begin
            if (c <= 30 && (c % 3) == 0) dut_if.mode_raw = ((c / 3) % 2) == 0;
            @(negedge clk);
            check($sformatf("bounce_c%0d", c), obs(),
                  expv(8'h00, 8'h00, (c >= 30 + LAT - 1), (c == 30 + LAT - 1)));
        end
        step_run("mode_rel", 8'h00, 8'h00, 1'b1, 1'b0, 22);

        // Simultaneous edges on several keys.
        step_run("simul_on",  8'h00, 8'hA5, 1'b0, 1'b0, 22);
        step_run("simul_off", 8'hA5, 8'h00, 1'b0, 1'b0, 22);

        // Reset in the middle of a count on key 7.
        dut_if.key_raw = 8'h80;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            check($sformatf("mid_cnt_c%0d", i), obs(), '0);
        end
        rst = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            check($sformatf("mid_rst_c%0d", i), obs(), '0);
        end
        rst = 1'b1;
        step_run("mid_rel", 8'h00, 8'h80, 1'b0, 1'b0, 22);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, board clock frequency in Hz.
REQ-002 Parameter DEBOUNCE_CYCLES, default 2_000_000 (20 ms at CLK_HZ), number of cycles an input must stay stable before it is accepted; legal range 2..2^24-1.
REQ-003 Parameter N_KEYS, default 8, number of piano key inputs.
REQ-004 clk  input  1  single system clock (P17 board clock); all logic is on its rising edge.
REQ-005 rst  input  1  reset, asynchronous assert, active-low (0 = reset), released synchronously to clk.
REQ-006 key_raw  input  N_KEYS  raw asynchronous piano switches; bit 0 is key 0 (lowest note).
REQ-007 mode_raw  input  1  raw asynchronous mode-select button.
REQ-008 key_level  output  N_KEYS  debounced key levels; drives the mode FSM key_board_in bus, with bit i mapped to key i.
REQ-009 key_press  output  N_KEYS  one-cycle pulse per debounced 0->1 transition of key i.
REQ-010 mode_level  output  1  debounced level of mode_raw.
REQ-011 mode_pulse  output  1  one-cycle pulse per debounced press of mode_raw; drives the mode FSM in input.
REQ-012 any_key  output  1  OR of key_level.

Function
REQ-013 Each of the N_KEYS+1 channels shall pass through a 2-flop synchronizer before any other logic.
REQ-014 Each channel shall hold a stable register and a counter of ceil(log2(DEBOUNCE_CYCLES)) bits.
REQ-015 While the synchronized value equals stable, the counter shall be held at 0.
REQ-016 While the synchronized value differs from stable, the counter shall increment by 1 per cycle.
REQ-017 When the counter equals DEBOUNCE_CYCLES-1 and the values still differ, stable shall take the synchronized value and the counter shall clear in the same cycle.
REQ-018 If the synchronized value returns to stable before the threshold, the counter shall clear and stable shall not change; glitches shorter than DEBOUNCE_CYCLES cycles are rejected.
REQ-019 Latency from a clean raw edge to the level output change shall be exactly DEBOUNCE_CYCLES+2 cycles.
REQ-020 The press pulse shall assert in the cycle stable goes 0->1 and last exactly one cycle; release edges produce no pulse.
REQ-021 Channels shall be fully independent; simultaneous edges on any set of channels shall each produce their own correct level change and pulse in the same cycle.
REQ-022 A held input shall produce exactly one pulse, with no auto-repeat; the counter shall never wrap.
REQ-023 An input held high across reset release shall be accepted after DEBOUNCE_CYCLES+2 cycles and shall produce one press pulse.

Reset
REQ-024 While rst=0, all synchronizer flops, stable registers, counters and pulse registers shall be 0.
REQ-025 While rst=0, key_level, key_press, mode_level, mode_pulse and any_key shall all be 0.
REQ-026 Reset asserted mid-count shall abort the count; after release, debouncing restarts from 0 with no pulse carried over.

Structure
REQ-027 CLK_HZ, N_KEYS and the default debounce time shall live in the shared piano_pkg constants file, which is also used by the mode FSM and the play modes.
REQ-028 One sub-module, debounce_bit (synchronizer, counter, stable register, press pulse for one channel), shall be instantiated N_KEYS+1 times.
REQ-029 key_debounce shall contain no state of its own beyond these instances; any_key is combinational.

Verification (bench uses DEBOUNCE_CYCLES=16)
REQ-030 Reset check: hold rst=0 for 5 cycles with all raw inputs at 1 -> all outputs 0; release rst -> key_level=8'hFF and mode_level=1 at cycle 18 after release, with one-cycle key_press=8'hFF and mode_pulse=1 in that cycle.
REQ-031 Glitch rejection: key_raw[3] high for 10 cycles, then low -> key_level and key_press stay 0 throughout.
REQ-032 Clean press and release: key_raw[0] rises and is held -> key_level[0]=1 exactly 18 cycles later with a single-cycle key_press[0]; drop it -> key_level[0]=0 18 cycles later with no pulse.
REQ-033 Bounce: mode_raw toggles every 3 cycles for 30 cycles, then holds 1 -> exactly one mode_pulse, 18 cycles after the last toggle.
REQ-034 Simultaneous keys: key_raw 8'h00 -> 8'hA5 in one cycle -> key_press=8'hA5 for one cycle, and key_level=8'hA5 with any_key=1.
REQ-035 Reset mid-count: key_raw[7] high, rst pulsed low at cycle 10 of the count -> no pulse before release; key_level[7]=1 18 cycles after release.
